// File: rtl/wr_ingress_ctrl_if.sv
// Upstream valid/ready word stream into the write-side ingress controller.
interface wr_ingress_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_ready;

    // Producer side of the stream.
    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    // Ingress controller side of the stream.
    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress for an async FIFO: 2-entry skid buffer feeding the
// FIFO memory, plus registered occupancy, almost-full and packet counter.
module wr_ingress_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 9,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned AFULL_THRESH = 4
) (
    input  logic                  w_clk,
    input  logic                  wrst,
    wr_ingress_ctrl_if.slave      s_if,
    input  logic                  f_full,
    input  logic [ADDR_WIDTH:0]   wptr,
    input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  almost_full,
    output logic [15:0]           pkt_count
);

    localparam int unsigned PTR_W       = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH       = 1 << ADDR_WIDTH;
    localparam int unsigned AFULL_LEVEL = DEPTH - AFULL_THRESH;
    localparam int unsigned CNT_W       = 16;

    typedef struct packed {
        logic                  last;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    entry_t            head_q, head_d;
    entry_t            tail_q, tail_d;
    entry_t            in_entry;
    logic              s_ready_q, s_ready_d;
    logic              accept;
    logic              wr;
    logic [PTR_W-1:0]  rptr_bin;
    logic [PTR_W-1:0]  ptr_diff;
    logic [PTR_W-1:0]  fill_level_q;
    logic              almost_full_q, almost_full_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;

    // Handshake qualifiers: accept from upstream, write into the FIFO.
    always_comb begin
        in_entry.data = s_if.s_data;
        in_entry.last = s_if.s_last;
        accept        = s_if.s_valid && s_ready_q;
        wr            = (state_q != ST_EMPTY) && !f_full;
    end

    // Skid-buffer occupancy FSM and entry movement; head is always the oldest word.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = in_entry;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !wr) begin
                    tail_d  = in_entry;
                    state_d = ST_TWO;
                end else if (!accept && wr) begin
                    state_d = ST_EMPTY;
                end else if (accept && wr) begin
                    // head drains this edge, so the incoming word replaces it
                    head_d  = in_entry;
                end
            end
            ST_TWO: begin
                if (wr) begin
                    head_d  = tail_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        s_ready_d = (state_d != ST_TWO);
    end

    // Gray-to-binary of the synchronized read pointer.
    always_comb begin
        rptr_bin = '0;
        for (int i = 0; i < PTR_W; i++) begin
            rptr_bin[i] = ^(rptr_gray_sync >> i);
        end
    end

    // Occupancy difference (modulo pointer range), almost-full and packet count next values.
    always_comb begin
        ptr_diff      = wptr - rptr_bin;
        almost_full_d = (ptr_diff >= PTR_W'(AFULL_LEVEL));
        pkt_count_d   = pkt_count_q + CNT_W'(wr && head_q.last);
    end

    // State, buffer and status registers with synchronous reset.
    always_ff @(posedge w_clk) begin
        if (wrst) begin
            state_q       <= ST_EMPTY;
            head_q        <= '0;
            tail_q        <= '0;
            s_ready_q     <= 1'b0;
            fill_level_q  <= '0;
            almost_full_q <= 1'b0;
            pkt_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            s_ready_q     <= s_ready_d;
            fill_level_q  <= ptr_diff;
            almost_full_q <= almost_full_d;
            pkt_count_q   <= pkt_count_d;
        end
    end

    // Output mapping.
    assign s_if.s_ready = s_ready_q;
    assign w_en         = wr;
    assign w_addr       = wptr[ADDR_WIDTH-1:0];
    assign w_data       = head_q.data;
    assign fill_level   = fill_level_q;
    assign almost_full  = almost_full_q;
    assign pkt_count    = pkt_count_q;

endmodule

// File: doc/wr_ingress_ctrl.md
WR_INGRESS_CTRL -- requirements
Module: wr_ingress_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- ADDR_WIDTH, 9, FIFO address bits; depth DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 32, payload width.
- AFULL_THRESH, 4, free-slot margin for almost_full.

REQ-002 Ports SHALL be, one per line:
- w_clk  in  1  write-domain clock.
- wrst  in  1  reset; synchronous, active-high.
- s_valid  in  1  upstream word valid.
- s_data  in  DATA_WIDTH  upstream word.
- s_last  in  1  upstream end-of-packet marker.
- s_ready  out  1  block can accept a word.
- f_full  in  1  FIFO full flag from the write-pointer stage.
- wptr  in  ADDR_WIDTH+1  binary write pointer from the write-pointer stage.
- rptr_gray_sync  in  ADDR_WIDTH+1  read pointer, Gray, already synchronized into w_clk.
- w_en  out  1  write request to the write-pointer stage and the FIFO memory.
- w_addr  out  ADDR_WIDTH  memory write address.
- w_data  out  DATA_WIDTH  memory write data.
- fill_level  out  ADDR_WIDTH+1  registered FIFO occupancy.
- almost_full  out  1  registered almost-full flag.
- pkt_count  out  16  packets committed to the FIFO.

Function
REQ-003 The block SHALL hold a 2-entry skid buffer (data plus last bit) with occupancy FSM states EMPTY, ONE, TWO.
REQ-004 Accept condition: s_valid && s_ready at a rising w_clk edge. s_ready SHALL be registered and equal 1 exactly when the state is not TWO.
REQ-005 Write condition: w_en = (state != EMPTY) && !f_full, combinational. w_data SHALL be the head entry and w_addr = wptr[ADDR_WIDTH-1:0].
REQ-006 FSM transitions SHALL be:
- EMPTY: accept -> ONE.
- ONE: accept without write -> TWO; write without accept -> EMPTY; both or neither -> ONE.
- TWO: write -> ONE (accept is impossible in TWO); otherwise stay TWO.
REQ-007 On simultaneous accept and write in ONE, the incoming word SHALL become the new head in the same edge.
REQ-008 Ordering SHALL be strict FIFO; a word accepted at edge k SHALL NOT drive w_en before cycle k+1.
REQ-009 While f_full=1, w_en SHALL be 0 and buffer contents SHALL be held unchanged.
REQ-010 Occupancy computation:
- rptr_bin is the Gray-to-binary conversion of rptr_gray_sync.
- fill_level SHALL register (wptr - rptr_bin) modulo 2**(ADDR_WIDTH+1) every cycle, giving one cycle of latency.
- The subtraction SHALL wrap correctly across pointer wrap-around.
REQ-011 almost_full SHALL register (wptr - rptr_bin) >= DEPTH - AFULL_THRESH, using the same combinational difference as fill_level.
REQ-012 pkt_count SHALL increment by 1 on each cycle where w_en=1 and the head last bit = 1, wrapping from 0xFFFF to 0.

Reset
REQ-013 With wrst=1 at an edge, the block SHALL reset to:
- state EMPTY, with buffer data cleared to 0;
- s_ready=0, fill_level=0, almost_full=0, pkt_count=0.
REQ-014 s_ready SHALL rise on the first edge after wrst deasserts.
REQ-015 A reset asserted mid-operation SHALL discard buffered words without generating w_en.
REQ-016 w_en SHALL be 0 during and immediately after reset, since the state is EMPTY.

Verification
REQ-017 Reset then single word: s_data=0xA5A5A5A5, s_last=1, accepted at edge 1 -> cycle 1 shows w_en=1, w_data=0xA5A5A5A5, w_addr=wptr[8:0]; pkt_count=1 after edge 2.
REQ-018 Backpressure: f_full=1 with 3 words offered -> 2 accepted, s_ready=0 thereafter, w_en=0; release f_full -> both words written in order on consecutive cycles, s_ready returns to 1.
REQ-019 Streaming: s_valid=1 continuously, f_full=0 -> the FSM stays in ONE, one write per cycle, no bubbles, data order preserved over 1000 words.
REQ-020 Wrap-around: wptr=10'h005 and rptr_gray_sync = Gray(10'h3FE) -> fill_level=7 one cycle later, almost_full=0; wptr=10'h1FC with rptr_bin=0 -> fill_level=508, almost_full=1.
REQ-021 Mid-operation reset: state TWO, then assert wrst for one edge -> state EMPTY, w_en=0, pkt_count=0, and no stale word is ever written.
REQ-022 pkt_count wrap: preload 0xFFFF, commit one s_last word -> pkt_count=0.
